fpu_result_fifo: RTL
====================

# fpu_result_fifo

Downstream capture stage for the floating-point adder. It buffers each result word and its one-hot status into a first-word-fall-through FIFO that a consumer drains with a valid/ready handshake. In parallel it keeps saturating per-status event counters, sticky status flags and a dropped-result counter, so software or the test harness can audit an entire run of operations. The FPU cannot be stalled, so results that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2.
- CNT_W, 16: width of every statistics counter.

Ports:
- clock100KHz  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  one-cycle strobe; in_data and in_status carry a new FPU result.
- in_data  in  32  result word: sign[31], exponent[30:25], mantissa[24:0].
- in_status  in  4  one-hot status: 0001 exact, 0010 inexact, 0100 overflow, 1000 underflow.
- in_ready  out  1  equals !full; informational only, the producer does not wait on it.
- out_valid  out  1  FIFO non-empty.
- out_data  out  32  head entry data; 0 when empty.
- out_status  out  4  head entry status; 0 when empty.
- out_ready  in  1  consumer pops the head when out_valid && out_ready.
- level  out  $clog2(DEPTH)+1  current occupancy.
- clear  in  1  clears counters and sticky flags; FIFO contents are unaffected.
- sticky_status  out  4  OR of every in_status sampled since the last reset or clear.
- bad_status  out  1  sticky; set when a sampled in_status is not one-hot (includes 0000).
- cnt_exact, cnt_inexact, cnt_ovf, cnt_unf  out  CNT_W each  saturating event counts per status.
- drop_count  out  CNT_W  saturating count of results dropped because the FIFO was full.

## Operation
- Reset values:
  - Pointers, level, all counters, sticky_status and bad_status are 0.
  - out_valid = 0, out_data = 0, out_status = 0, in_ready = 1.
- Write: in_valid && !full stores {in_status, in_data} at the write pointer, which then advances modulo DEPTH.
- Drop: in_valid && full leaves the FIFO unchanged and increments drop_count.
- Read: out_valid && out_ready advances the read pointer. out_ready is ignored while the FIFO is empty.
- Simultaneous read and write:
  - Not full: both happen and level is unchanged.
  - Full: the pop happens and the incoming write is dropped (counted). in_ready has no combinational path from out_ready.
- Full/empty detection: pointers are $clog2(DEPTH)+1 bits wide (extra wrap bit). Full = same index with differing wrap bit; empty = pointers equal.
- Statistics are collected on every in_valid, whether or not the write is accepted:
  - The counter selected by the one-hot bit increments.
  - sticky_status |= in_status.
  - A non-one-hot status increments no per-status counter and sets bad_status.
- Saturation: every counter stops at 2^CNT_W−1 and never wraps.
- clear vs in_valid in the same cycle: clear wins for counters and flags, so that sample's statistics are discarded. The FIFO write still occurs. drop_count is also cleared.
- Reset mid-operation: all FIFO contents are discarded and every output returns to its reset value on the next edge.

## Timing
- Write-to-visibility: an entry written at edge N gives out_valid = 1 with that entry's data and status from after edge N.
- Pop: the next entry, or empty, appears after the popping edge; out_data and out_status are combinational reads of the head entry.
- Counters, flags, level and drop_count update at the same edge as the event, with no extra latency.
- Peak throughput is one write and one read per cycle. The FPU produces at most one result per 5 cycles.

## Structure
- Shared package fpu_pkg holds:
  - The status enum (EXACT, INEXACT, OVERFLOW, UNDERFLOW).
  - Field constants: SIGN_BIT = 31, EXP_MSB = 30, EXP_LSB = 25, MANT_W = 25, EXP_W = 6.
  - A packed result struct {status, data} of 36 bits.
- Sub-module sync_fifo, parameterised on width and depth, contains the storage, pointers and level.
- Statistics logic lives in the top level.

## Test plan
- Reset, then write 32'h4080_0000 with status 0001 → next cycle out_valid = 1, out_data = 32'h4080_0000, out_status = 0001, level = 1, cnt_exact = 1.
- With out_ready = 0, write 10 results (DEPTH = 8) → level = 8, in_ready = 0, drop_count = 2; popping all 8 returns the first 8 results in order.
- With the FIFO full, pop and write in the same cycle → pop succeeds, the write is dropped, level = 7, drop_count increments.
- Feed statuses 0010, 0100, 1000, 0000 → cnt_inexact = 1, cnt_ovf = 1, cnt_unf = 1, sticky_status = 1110, bad_status = 1.
- With CNT_W = 4, feed 20 exact results → cnt_exact = 15, then assert clear together with in_valid → cnt_exact = 0 and the FIFO level still increments.
- Assert reset with the FIFO holding 3 entries → next cycle out_valid = 0, level = 0, all counters = 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and field constants for the floating-point adder result path.
// The result word and its one-hot status travel together as one 36-bit record.
package fpu_pkg;

    typedef enum logic [3:0] {
        EXACT     = 4'b0001,
        INEXACT   = 4'b0010,
        OVERFLOW  = 4'b0100,
        UNDERFLOW = 4'b1000
    } fpu_status_e;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 25;
    localparam int MANT_W   = 25;
    localparam int EXP_W    = 6;
    localparam int DATA_W   = 32;
    localparam int STATUS_W = 4;
    localparam int RESULT_W = STATUS_W + DATA_W;

    typedef struct packed {
        logic [STATUS_W-1:0] status;
        logic [DATA_W-1:0]   data;
    } fpu_result_t;

    // Exactly one bit set; 0000 is not one-hot.
    function automatic logic is_one_hot(input logic [STATUS_W-1:0] s);
        return (s != '0) && ((s & (s - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on rd_data.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic                     clock100KHz,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_fire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clock100KHz) begin
        if (wr_fire) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fpu_result_fifo.sv
// Capture stage behind the FP adder: buffers results for a valid/ready consumer
// and keeps saturating per-status, drop and sticky statistics for auditing a run.
module fpu_result_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clock100KHz,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    input  logic [3:0]               in_status,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_data,
    output logic [3:0]               out_status,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     clear,
    output logic [3:0]               sticky_status,
    output logic                     bad_status,
    output logic [CNT_W-1:0]         cnt_exact,
    output logic [CNT_W-1:0]         cnt_inexact,
    output logic [CNT_W-1:0]         cnt_ovf,
    output logic [CNT_W-1:0]         cnt_unf,
    output logic [CNT_W-1:0]         drop_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    fpu_result_t      wr_result;
    fpu_result_t      rd_result;
    logic             full;
    logic             empty;
    logic             status_ok;
    logic [CNT_W-1:0] status_cnt_reg [STATUS_W];
    logic [CNT_W-1:0] drop_count_reg;
    logic [3:0]       sticky_status_reg;
    logic             bad_status_reg;

    assign wr_result.status = in_status;
    assign wr_result.data   = in_data;

    sync_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock100KHz (clock100KHz),
        .reset       (reset),
        .wr_en       (in_valid),
        .wr_data     (wr_result),
        .rd_en       (out_ready),
        .rd_data     (rd_result),
        .full        (full),
        .empty       (empty),
        .level       (level)
    );

    assign in_ready   = !full;
    assign out_valid  = !empty;
    assign out_data   = empty ? '0 : rd_result.data;
    assign out_status = empty ? '0 : rd_result.status;
    assign status_ok  = is_one_hot(in_status);

    // Statistics sample every strobe, accepted or dropped; clear overrides the sample.
    genvar gi;
    generate
        for (gi = 0; gi < STATUS_W; gi++) begin : g_status_cnt
            always_ff @(posedge clock100KHz) begin
                if (reset || clear) begin
                    status_cnt_reg[gi] <= '0;
                end else if (in_valid && status_ok && in_status[gi] &&
                             status_cnt_reg[gi] != CNT_MAX) begin
                    status_cnt_reg[gi] <= status_cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock100KHz) begin
        if (reset || clear) begin
            drop_count_reg    <= '0;
            sticky_status_reg <= '0;
            bad_status_reg    <= 1'b0;
        end else if (in_valid) begin
            sticky_status_reg <= sticky_status_reg | in_status;
            if (!status_ok) bad_status_reg <= 1'b1;
            if (full && drop_count_reg != CNT_MAX)
                drop_count_reg <= drop_count_reg + 1'b1;
        end
    end

    assign cnt_exact     = status_cnt_reg[0];
    assign cnt_inexact   = status_cnt_reg[1];
    assign cnt_ovf       = status_cnt_reg[2];
    assign cnt_unf       = status_cnt_reg[3];
    assign drop_count    = drop_count_reg;
    assign sticky_status = sticky_status_reg;
    assign bad_status    = bad_status_reg;

endmodule
